// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the memory boot loader
package boot_pkg;

    typedef enum logic [1:0] {BOOT_IDLE, BOOT_LOAD, BOOT_DONE} boot_state_e;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/boot_word_sel.sv
// rtl/boot_word_sel.sv - combinational little-endian word extractor from a byte image
module boot_word_sel
    import boot_pkg::*;
#(
    parameter int SIZE_BYTES = 32,
    parameter int ADDR_W     = 5,
    parameter int K_W        = 3
) (
    input  logic [SIZE_BYTES-1:0][7:0] image,
    input  logic [K_W-1:0]             k,
    output word_t                      wr_data,
    output logic [ADDR_W-1:0]          wr_addr
);

    // The packed slice puts image[4k+3] in the top byte, giving little-endian order.
    assign wr_data = image[int'(k)*WORD_BYTES +: WORD_BYTES];
    assign wr_addr = ADDR_W'(int'(k) * WORD_BYTES);

endmodule

// File: rtl/mem_boot_loader.sv
// rtl/mem_boot_loader.sv - copies a byte image into a memory bank word by word, holding the core until done
// Optional running checksum of written words: define MEM_BOOT_LOADER_CHECKSUM_EN.
module mem_boot_loader
    import boot_pkg::*;
#(
    parameter int SIZE_BYTES = 32,
    parameter int ADDR_W     = (SIZE_BYTES > 4) ? $clog2(SIZE_BYTES) : 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SIZE_BYTES-1:0][7:0] image,
    input  logic                       reload,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [31:0]                wr_data,
    output logic                       boot_done,
    output logic                       core_hold,
    output logic [31:0]                checksum
);

    localparam int N_WORDS = SIZE_BYTES / WORD_BYTES;
    localparam int K_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_WORDS - 1);

    if (SIZE_BYTES == 0 || (SIZE_BYTES % WORD_BYTES) != 0) begin : g_bad_size
        $error("mem_boot_loader: SIZE_BYTES must be a non-zero multiple of 4");
    end

    boot_state_e    state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic           xfer;

    assign xfer = (state_q == BOOT_LOAD) && wr_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            BOOT_IDLE: begin
                state_d = BOOT_LOAD;
                k_d     = '0;
            end
            BOOT_LOAD: begin
                if (wr_ready) begin
                    if (k_q == K_LAST) begin
                        state_d = BOOT_DONE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            BOOT_DONE: begin
                if (reload) begin
                    state_d = BOOT_LOAD;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = BOOT_IDLE;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Control outputs decode only the registered state, so reset clears them at once.
    assign wr_valid  = (state_q == BOOT_LOAD);
    assign boot_done = (state_q == BOOT_DONE);
    assign core_hold = !boot_done;

    boot_word_sel #(
        .SIZE_BYTES (SIZE_BYTES),
        .ADDR_W     (ADDR_W),
        .K_W        (K_W)
    ) u_word_sel (
        .image   (image),
        .k       (k_q),
        .wr_data (wr_data),
        .wr_addr (wr_addr)
    );

`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
    word_t checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q != BOOT_LOAD && state_d == BOOT_LOAD) begin
            checksum_d = '0;
        end else if (xfer) begin
            checksum_d = checksum_q + wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_boot_loader.sv
// tb/tb_mem_boot_loader.sv - directed self-checking bench for mem_boot_loader
module tb_mem_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            reload;
    logic            wr_ready;
    logic [31:0][7:0] image;
    logic            wr_valid;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_data;
    logic            boot_done;
    logic            core_hold;
    logic [31:0]     checksum;

    logic            reset4;
    logic            reload4;
    logic            wr_ready4;
    logic [3:0][7:0] image4;
    logic            wr_valid4;
    logic [1:0]      wr_addr4;
    logic [31:0]     wr_data4;
    logic            boot_done4;
    logic            core_hold4;
    logic [31:0]     checksum4;

    mem_boot_loader #(.SIZE_BYTES(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .image     (image),
        .reload    (reload),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .boot_done (boot_done),
        .core_hold (core_hold),
        .checksum  (checksum)
    );

    mem_boot_loader #(.SIZE_BYTES(4)) dut4 (
        .clk       (clk),
        .reset     (reset4),
        .image     (image4),
        .reload    (reload4),
        .wr_valid  (wr_valid4),
        .wr_ready  (wr_ready4),
        .wr_addr   (wr_addr4),
        .wr_data   (wr_data4),
        .boot_done (boot_done4),
        .core_hold (core_hold4),
        .checksum  (checksum4)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] addr_q[$];
    logic [31:0] data_q[$];
    logic        first_hold;
    int          edges;
    int          cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        return {image[4*k+3], image[4*k+2], image[4*k+1], image[4*k]};
    endfunction

    function automatic logic [31:0] exp_sum();
        logic [31:0] s;
        s = 32'h0;
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
        for (int k = 0; k < 8; k++) s = s + exp_word(k);
`endif
        return s;
    endfunction

    // Drives wr_ready/reload per LOAD cycle at negedges, records transfers, returns
    // the number of clock edges until boot_done is seen (-1 on timeout).
    task automatic run_pass(input int stall_first, input int stall_last, input int reload_at,
                            output int n_edges);
        int lc;
        lc = 0;
        n_edges = -1;
        addr_q.delete();
        data_q.delete();
        for (int e = 0; e < 100; e++) begin
            @(negedge clk);
            reload = 1'b0;
            if (e == 0) first_hold = core_hold;
            if (boot_done) begin
                n_edges = e + 1;
                break;
            end
            wr_ready = 1'b1;
            if (wr_valid) begin
                wr_ready = !(lc >= stall_first && lc <= stall_last);
                reload   = (lc == reload_at);
                lc++;
            end
            #1;
            if (wr_valid && !wr_ready)
                chk("stall_addr_hold", 32'(wr_addr), 32'(addr_q.size() * 4));
            if (wr_valid && wr_ready) begin
                addr_q.push_back(32'(wr_addr));
                data_q.push_back(wr_data);
            end
        end
    endtask

    task automatic check_pass(input string tag, input int n_edges, input int exp_edges);
        chk({tag, "_edges"}, 32'(n_edges), 32'(exp_edges));
        chk({tag, "_nwrites"}, 32'(addr_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < addr_q.size(); k++) begin
            chk({tag, "_addr"}, addr_q[k], 32'(4 * k));
            chk({tag, "_data"}, data_q[k], exp_word(k));
        end
        chk({tag, "_checksum"}, checksum, exp_sum());
        chk({tag, "_hold_during"}, 32'(first_hold), 32'd1);
        chk({tag, "_hold_after"}, 32'(core_hold), 32'd0);
        chk({tag, "_valid_after"}, 32'(wr_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        reload    = 1'b0;
        wr_ready  = 1'b1;
        reset4    = 1'b1;
        reload4   = 1'b0;
        wr_ready4 = 1'b1;
        image4    = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 32; i++) image[i] = 8'(i);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(wr_valid), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", wr_data, 32'h03020100);
        chk("rst_done", 32'(boot_done), 32'd0);
        chk("rst_hold", 32'(core_hold), 32'd1);
        chk("rst_checksum", checksum, 32'd0);

        // Test 1: free-running load
        @(negedge clk);
        reset = 1'b0;
        run_pass(-1, -1, -1, edges);
        check_pass("t1", edges, 9);

        // Test 2: three stall cycles, plus a reload pulse during LOAD
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_pass(2, 4, 3, edges);
        check_pass("t2", edges, 12);

        // Test 3: asynchronous reset while word 5 is pending
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (wr_valid && wr_addr == 5'h14) break;
        end
        chk("t3_reached_word5", 32'(wr_addr), 32'h14);
        reset = 1'b1;
        #1;
        chk("t3_async_valid", 32'(wr_valid), 32'd0);
        chk("t3_async_hold", 32'(core_hold), 32'd1);
        chk("t3_async_done", 32'(boot_done), 32'd0);
        chk("t3_async_checksum", checksum, 32'd0);
        chk("t3_async_addr", 32'(wr_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_pass(-1, -1, -1, edges);
        check_pass("t3", edges, 9);

        // Test 4: reload from DONE with a new image
        for (int i = 0; i < 32; i++) image[i] = 8'hFF;
        reload = 1'b1;
        run_pass(-1, -1, -1, edges);
        check_pass("t4", edges, 9);

        // Test 5: reload sampled on the DONE-entry edge is ignored
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_pass(-1, -1, 7, edges);
        check_pass("t5", edges, 9);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (wr_valid) cnt++;
        end
        chk("t5_no_second_pass", 32'(cnt), 32'd0);
        chk("t5_still_done", 32'(boot_done), 32'd1);

        // Test 6: single-word image
        @(negedge clk);
        reset4 = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_valid", 32'(wr_valid4), 32'd1);
        chk("t6_addr", 32'(wr_addr4), 32'd0);
        chk("t6_data", wr_data4, 32'hEFBEADDE);
        chk("t6_hold", 32'(core_hold4), 32'd1);
        @(negedge clk);
        #1;
        chk("t6_done", 32'(boot_done4), 32'd1);
        chk("t6_valid_after", 32'(wr_valid4), 32'd0);
        chk("t6_hold_after", 32'(core_hold4), 32'd0);
`ifdef MEM_BOOT_LOADER_CHECKSUM_EN
        chk("t6_checksum", checksum4, 32'hEFBEADDE);
`else
        chk("t6_checksum", checksum4, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
